// File: rtl/seq_right_shifter.sv
// Sequential right shifter: shifts a captured operand one bit per clock,
// logical or arithmetic, and presents the registered result with a done pulse.
module seq_right_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [SHW-1:0]   shamt,
    input  logic             arith,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] shifted_s;

    // One-bit shift step; the vacated MSB copies the sign only in arithmetic mode.
    always_comb begin
        shifted_s = {mode_q & work_q[WIDTH-1], work_q[WIDTH-1:1]};
    end

    // Next-state and datapath update: accept, shift step, completion.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        dout_d  = dout_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    work_d = din;
                    cnt_d  = shamt;
                    mode_d = arith;
                    if (shamt == {SHW{1'b0}}) begin
                        // Zero distance completes immediately with the operand itself.
                        state_d = ST_DONE;
                        dout_d  = din;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                work_d = shifted_s;
                cnt_d  = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d = ST_DONE;
                    dout_d  = shifted_s;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and status registers; status is decoded from the next state
    // so busy/done come straight from flops and still match the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            work_q  <= {WIDTH{1'b0}};
            cnt_q   <= {SHW{1'b0}};
            mode_q  <= 1'b0;
            dout_q  <= {WIDTH{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            dout_q  <= dout_d;
            busy_q  <= (state_d == ST_SHIFT);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dout = dout_q;

endmodule

// File: tb/tb_seq_right_shifter.sv
// Self-checking bench for seq_right_shifter: directed corner cases plus
// randomized operations checked against an arithmetic reference.
module tb_seq_right_shifter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] din;
    logic [4:0]  shamt;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] dout;

    int          n_cmp;
    int          n_bad;
    logic [31:0] last_res;

    seq_right_shifter #(.WIDTH(32), .SHW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .din   (din),
        .shamt (shamt),
        .arith (arith),
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s, input logic a);
        logic [31:0] r;
        if (a) r = $signed(d) >>> s;
        else   r = d >> s;
        return r;
    endfunction

    // Called at a negedge; returns at the negedge where done should be high.
    // poke=1 pulses start with an all-ones operand during the shift phase.
    task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic a, input bit poke);
        logic [31:0] exp;
        int          n;
        int          hold_err;
        int          early_done;
        exp        = ref_shift(d, s, a);
        start      = 1'b1;
        din        = d;
        shamt      = s;
        arith      = a;
        @(negedge clk);
        start      = 1'b0;
        din        = $urandom;
        shamt      = 5'($urandom);
        arith      = 1'($urandom);
        n          = 0;
        hold_err   = 0;
        early_done = 0;
        while (busy && n < 40) begin
            if (dout !== last_res) hold_err++;
            if (done) early_done++;
            if (poke && n == 1) begin
                start = 1'b1;
                din   = 32'hFFFF_FFFF;
                shamt = 5'd1;
            end else begin
                start = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        check_eq("busy_cycles", 32'(n), 32'(s));
        check_eq("dout_hold", 32'(hold_err), 32'd0);
        check_eq("done_early", 32'(early_done), 32'd0);
        check_eq("done_pulse", {31'd0, done}, 32'd1);
        check_eq("dout", dout, exp);
        last_res = exp;
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        last_res = 32'd0;
        rst_n    = 1'b0;
        start    = 1'b0;
        din      = 32'd0;
        shamt    = 5'd0;
        arith    = 1'b0;
        #12;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_dout", dout, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(32'h8000_0000, 5'd4, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("idle_after_done", {31'd0, done}, 32'd0);
        run_op(32'h8000_0000, 5'd4, 1'b1, 1'b0);
        @(negedge clk);
        run_op(32'h8000_0000, 5'd31, 1'b1, 1'b0);
        @(negedge clk);
        run_op(32'h1234_5678, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        run_op(32'h0000_0010, 5'd2, 1'b0, 1'b0);
        @(negedge clk);

        // A start pulse during shifting must be dropped, leaving one done pulse.
        run_op(32'h0000_00F0, 5'd4, 1'b0, 1'b1);
        @(negedge clk);
        check_eq("single_done", {31'd0, done}, 32'd0);
        check_eq("no_queued_op", {31'd0, busy}, 32'd0);
        check_eq("dout_kept", dout, 32'h0000_000F);

        // Back-to-back: second request issued in the done cycle.
        run_op(32'h0000_0100, 5'd3, 1'b0, 1'b0);
        run_op(32'h0000_0100, 5'd8, 1'b0, 1'b0);
        @(negedge clk);

        // Reset in the middle of a long shift.
        start = 1'b1; din = 32'hDEAD_BEEF; shamt = 5'd20; arith = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("busy_before_rst", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_mid_done", {31'd0, done}, 32'd0);
        check_eq("rst_mid_dout", dout, 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        last_res = 32'd0;
        begin
            int dn;
            dn = 0;
            repeat (25) begin
                @(negedge clk);
                if (done || busy) dn++;
            end
            check_eq("no_done_after_abort", 32'(dn), 32'd0);
        end
        run_op(32'hF000_0000, 5'd3, 1'b1, 1'b0);
        @(negedge clk);

        // Randomized operations, sometimes chained back-to-back.
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            run_op($urandom, 5'($urandom), 1'($urandom), 1'b0);
        end
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
